hwpe_stream_skid_buffer: RTL and testbench

HWPE_STREAM_SKID_BUFFER -- requirements
Module: hwpe_stream_skid_buffer

---
 rtl/hwpe_stream_package.sv | 11 +
 rtl/hwpe_stream_intf_stream.sv | 26 ++
 rtl/hwpe_stream_skid_buffer.sv | 93 +++++++++
 tb/tb_hwpe_stream_skid_buffer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/hwpe_stream_package.sv
// Shared types for the HWPE streaming blocks.
// The skid-buffer state encoding doubles as the beat count it holds.
package hwpe_stream_package;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Valid/ready stream bundle carrying a data word and its byte strobes.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport sink (
        input  valid,
        input  data,
        input  strb,
        output ready
    );

    modport source (
        output valid,
        output data,
        output strb,
        input  ready
    );

endinterface

// File: rtl/hwpe_stream_skid_buffer.sv
// Two-slot skid buffer: registered valid/ready/payload on both sides, so no
// combinational path crosses from pop ready back to push ready.
module hwpe_stream_skid_buffer
    import hwpe_stream_package::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clear_i,
    hwpe_stream_intf_stream.sink          push_i,
    hwpe_stream_intf_stream.source        pop_o,
    output logic [1:0]                    occupancy_o
);

    skid_state_t           state_q;
    logic [DATA_WIDTH-1:0] main_data_q;
    logic [STRB_WIDTH-1:0] main_strb_q;
    logic [DATA_WIDTH-1:0] skid_data_q;
    logic [STRB_WIDTH-1:0] skid_strb_q;
    logic                  push_ready_q;
    logic                  pop_valid_q;

    logic push_hs;
    logic pop_hs;

    assign push_hs = push_i.valid & push_ready_q;
    assign pop_hs  = pop_valid_q & pop_o.ready;

    // Ready/valid are tracked as their own flops rather than decoded from
    // state_q so that both stream sides see plain register outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StEmpty;
            main_data_q  <= '0;
            main_strb_q  <= '0;
            skid_data_q  <= '0;
            skid_strb_q  <= '0;
            push_ready_q <= 1'b1;
            pop_valid_q  <= 1'b0;
        end else if (clear_i) begin
            state_q      <= StEmpty;
            push_ready_q <= 1'b1;
            pop_valid_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (push_hs) begin
                        main_data_q <= push_i.data;
                        main_strb_q <= push_i.strb;
                        pop_valid_q <= 1'b1;
                        state_q     <= StOne;
                    end
                end
                StOne: begin
                    if (push_hs && pop_hs) begin
                        main_data_q <= push_i.data;
                        main_strb_q <= push_i.strb;
                    end else if (push_hs) begin
                        skid_data_q  <= push_i.data;
                        skid_strb_q  <= push_i.strb;
                        push_ready_q <= 1'b0;
                        state_q      <= StTwo;
                    end else if (pop_hs) begin
                        pop_valid_q <= 1'b0;
                        state_q     <= StEmpty;
                    end
                end
                StTwo: begin
                    if (pop_hs) begin
                        main_data_q  <= skid_data_q;
                        main_strb_q  <= skid_strb_q;
                        push_ready_q <= 1'b1;
                        state_q      <= StOne;
                    end
                end
                default: begin
                    push_ready_q <= 1'b1;
                    pop_valid_q  <= 1'b0;
                    state_q      <= StEmpty;
                end
            endcase
        end
    end

    assign push_i.ready = push_ready_q;
    assign pop_o.valid  = pop_valid_q;
    assign pop_o.data   = main_data_q;
    assign pop_o.strb   = main_strb_q;
    assign occupancy_o  = state_q;

endmodule

// File: tb/tb_hwpe_stream_skid_buffer.sv
// Directed and random stimulus for the skid buffer; a queue of accepted beats
// is the reference for payload order, occupancy and handshake flags.
module tb_hwpe_stream_skid_buffer;

    logic       clk;
    logic       rst;
    logic       clear;
    logic [1:0] occupancy;

    hwpe_stream_intf_stream #(.DATA_WIDTH(32), .STRB_WIDTH(4)) push ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(32), .STRB_WIDTH(4)) pop ();

    hwpe_stream_skid_buffer #(
        .DATA_WIDTH(32),
        .STRB_WIDTH(4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (clear),
        .push_i      (push),
        .pop_o       (pop),
        .occupancy_o (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_fail;
    int          n_pushed;
    int          n_popped;
    logic [35:0] sb[$];
    bit          stall_q;
    logic [35:0] stall_beat;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Compare outputs against the reference at the falling edge, then apply
    // this cycle's handshakes to the reference and return just after the
    // next rising edge, where the caller drives new inputs.
    task automatic cycle();
        logic push_hs;
        logic pop_hs;
        @(negedge clk);
        check("occupancy", 64'(occupancy), 64'(sb.size()));
        check("push_ready", 64'(push.ready), 64'(sb.size() < 2));
        check("pop_valid", 64'(pop.valid), 64'(sb.size() > 0));
        if (sb.size() > 0) check("pop_payload", 64'({pop.strb, pop.data}), 64'(sb[0]));
        if (stall_q) check("stall_stable", 64'({pop.strb, pop.data}), 64'(stall_beat));
        push_hs    = push.valid && push.ready;
        pop_hs     = pop.valid && pop.ready;
        stall_q    = pop.valid && !pop.ready && !rst && !clear;
        stall_beat = {pop.strb, pop.data};
        if (rst) begin
            sb.delete();
        end else begin
            if (pop_hs && sb.size() > 0) begin
                void'(sb.pop_front());
                n_popped++;
            end
            if (clear) begin
                sb.delete();
            end else if (push_hs) begin
                sb.push_back({push.strb, push.data});
                n_pushed++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] s,
                         input logic r);
        push.valid = v;
        push.data  = d;
        push.strb  = s;
        pop.ready  = r;
    endtask

    initial begin
        int push_base;
        int pop_base;
        n_checks = 0;
        n_fail   = 0;
        n_pushed = 0;
        n_popped = 0;
        stall_q  = 1'b0;
        rst      = 1'b1;
        clear    = 1'b0;
        drive(1'b0, 32'h0, 4'h0, 1'b0);
        cycle();
        cycle();
        rst = 1'b0;
        check("reset_data", 64'(pop.data), 64'h0);

        // Single beat: one cycle of latency to pop valid.
        drive(1'b1, 32'hA5A5_A5A5, 4'hF, 1'b1);
        cycle();
        drive(1'b0, 32'hDEAD_BEEF, 4'h3, 1'b1);
        check("first_valid", 64'(pop.valid), 64'h1);
        check("first_data", 64'(pop.data), 64'hA5A5_A5A5);
        check("first_occ", 64'(occupancy), 64'h1);
        cycle();
        cycle();

        // Back-to-back stream with ready held high.
        for (int i = 1; i <= 20; i++) begin
            drive(1'b1, 32'(i), 4'hF, 1'b1);
            cycle();
        end
        drive(1'b0, 32'h0, 4'h0, 1'b1);
        cycle();
        cycle();

        // Fill both slots under backpressure, then release.
        drive(1'b1, 32'h11, 4'h1, 1'b0);
        cycle();
        drive(1'b1, 32'h22, 4'h2, 1'b0);
        cycle();
        drive(1'b1, 32'h33, 4'h4, 1'b0);
        cycle();
        cycle();
        check("two_occ", 64'(occupancy), 64'h2);
        check("two_ready", 64'(push.ready), 64'h0);
        check("two_data", 64'(pop.data), 64'h11);
        drive(1'b0, 32'h0, 4'h0, 1'b1);
        cycle();
        check("release_data", 64'(pop.data), 64'h22);
        cycle();
        cycle();

        // Clear while full, with a same-cycle push and pop.
        drive(1'b1, 32'h44, 4'h1, 1'b0);
        cycle();
        drive(1'b1, 32'h55, 4'h2, 1'b0);
        cycle();
        drive(1'b1, 32'h66, 4'h3, 1'b1);
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        drive(1'b0, 32'h0, 4'h0, 1'b1);
        check("clear_valid", 64'(pop.valid), 64'h0);
        check("clear_ready", 64'(push.ready), 64'h1);
        check("clear_occ", 64'(occupancy), 64'h0);
        cycle();

        // Reset while full.
        drive(1'b1, 32'h77, 4'h7, 1'b0);
        cycle();
        drive(1'b1, 32'h88, 4'h8, 1'b0);
        cycle();
        rst = 1'b1;
        drive(1'b0, 32'h0, 4'h0, 1'b0);
        cycle();
        rst = 1'b0;
        check("rst_valid", 64'(pop.valid), 64'h0);
        check("rst_data", 64'(pop.data), 64'h0);
        check("rst_strb", 64'(pop.strb), 64'h0);
        check("rst_ready", 64'(push.ready), 64'h1);
        pop.ready = 1'b1;
        cycle();
        cycle();

        // Random valid/ready traffic.
        push_base = n_pushed;
        pop_base  = n_popped;
        for (int c = 0; c < 60000 && (n_pushed - push_base) < 10000; c++) begin
            drive(($urandom_range(0, 3) != 0), $urandom, 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) != 0));
            cycle();
        end
        drive(1'b0, 32'h0, 4'h0, 1'b1);
        for (int c = 0; c < 8 && sb.size() > 0; c++) cycle();
        cycle();
        check("random_beats", 64'(n_pushed - push_base), 64'd10000);
        check("random_delivered", 64'(n_popped - pop_base), 64'(n_pushed - push_base));
        check("drained", 64'(sb.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
